// File: rtl/hist2d_bin_out_stream.sv
// rtl/hist2d_bin_out_stream.sv - 2-D histogram accumulator with raster-order bin streaming
//
// Counts (I,Q) samples into a 2^AXIS_W x 2^AXIS_W grid of saturating
// counters. On request it streams the active I x Q bins out, one per cycle.
//
// Ports:
//   clk100          system clock, rising edge
//   rst_n           asynchronous active-low reset
//   data_in         sample strobe, one sample per high cycle
//   i_bin_coord     I bin index of the sample
//   q_bin_coord     Q bin index of the sample
//   start_data_out  request to stream the histogram
//   num_data_pts    maximum accepted samples per histogram
//   i_bin_num       active I bins (static)
//   q_bin_num       active Q bins (static)
//   data_out        valid strobe for bin_val / i_bin_out / q_bin_out
//   bin_val         count of the streamed bin
//   i_bin_out       I index of the streamed bin
//   q_bin_out       Q index of the streamed bin
//
// Build option: HIST2D_CLEAR_ON_READ_EN - when defined, streaming zeroes each
// bin as it is read and clears the accepted-sample counter on return to IDLE.

module hist2d_bin_out_stream #(
    parameter int AXIS_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic [7:0]       i_bin_coord,
    input  logic [7:0]       q_bin_coord,
    input  logic             start_data_out,
    input  logic [15:0]      num_data_pts,
    input  logic [7:0]       i_bin_num,
    input  logic [7:0]       q_bin_num,
    output logic             data_out,
    output logic [CNT_W-1:0] bin_val,
    output logic [7:0]       i_bin_out,
    output logic [7:0]       q_bin_out
);

    localparam int NAX   = 1 << AXIS_W;
    localparam int NBINS = NAX * NAX;
    localparam int AW2   = 2 * AXIS_W;

`ifdef HIST2D_CLEAR_ON_READ_EN
    localparam bit CLEAR_ON_READ = 1'b1;
`else
    localparam bit CLEAR_ON_READ = 1'b0;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mem_q [NBINS];
    logic [15:0]      acc_cnt_q, acc_cnt_d;
    logic [7:0]       i_idx_q, i_idx_d;
    logic [7:0]       q_idx_q, q_idx_d;
    logic             data_out_q, data_out_d;
    logic [CNT_W-1:0] bin_val_q, bin_val_d;
    logic [7:0]       i_out_q, i_out_d;
    logic [7:0]       q_out_q, q_out_d;

    logic [8:0]       i_eff, q_eff;
    logic             acc_en;
    logic [AW2-1:0]   acc_addr;
    logic [CNT_W-1:0] inc_val;
    logic             emit_en;
    logic [AW2-1:0]   emit_addr;
    logic             i_last, q_last;
    logic             clr_acc;

    // Bin counts wider than the storage are clamped to the grid size; 9 bits
    // so that a full 2^8 axis still fits.
    always_comb begin
        i_eff = ({1'b0, i_bin_num} > 9'(NAX)) ? 9'(NAX) : {1'b0, i_bin_num};
        q_eff = ({1'b0, q_bin_num} > 9'(NAX)) ? 9'(NAX) : {1'b0, q_bin_num};
    end

    // Accumulation path; the full 8-bit coordinates are range-checked before
    // truncation so out-of-range samples cannot alias onto valid bins.
    always_comb begin
        acc_en   = (state_q == IDLE) && data_in
                && ({1'b0, i_bin_coord} < i_eff)
                && ({1'b0, q_bin_coord} < q_eff)
                && (acc_cnt_q < num_data_pts);
        acc_addr = {q_bin_coord[AXIS_W-1:0], i_bin_coord[AXIS_W-1:0]};
        inc_val  = (mem_q[acc_addr] == {CNT_W{1'b1}}) ? mem_q[acc_addr]
                                                      : mem_q[acc_addr] + 1'b1;
    end

    // The stream indices always name the bin currently on the outputs, so the
    // FSM stays in STREAM for exactly the cycles where data_out is high.
    always_comb begin
        i_last = ({1'b0, i_idx_q} == (i_eff - 9'd1));
        q_last = ({1'b0, q_idx_q} == (q_eff - 9'd1));
    end

    always_comb begin
        state_d = state_q;
        i_idx_d = i_idx_q;
        q_idx_d = q_idx_q;
        emit_en = 1'b0;
        clr_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_data_out && (i_eff != 9'd0) && (q_eff != 9'd0)) begin
                    state_d = STREAM;
                    emit_en = 1'b1;
                    i_idx_d = 8'd0;
                    q_idx_d = 8'd0;
                end
            end
            STREAM: begin
                if (i_last && q_last) begin
                    state_d = IDLE;
                    clr_acc = 1'b1;
                end else begin
                    emit_en = 1'b1;
                    if (i_last) begin
                        i_idx_d = 8'd0;
                        q_idx_d = q_idx_q + 8'd1;
                    end else begin
                        i_idx_d = i_idx_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign emit_addr = {q_idx_d[AXIS_W-1:0], i_idx_d[AXIS_W-1:0]};

    always_comb begin
        data_out_d = emit_en;
        bin_val_d  = emit_en ? mem_q[emit_addr] : bin_val_q;
        i_out_d    = emit_en ? i_idx_d : i_out_q;
        q_out_d    = emit_en ? q_idx_d : q_out_q;
        acc_cnt_d  = acc_en ? acc_cnt_q + 16'd1 : acc_cnt_q;
        if (CLEAR_ON_READ && clr_acc) begin
            acc_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_cnt_q  <= 16'd0;
            i_idx_q    <= 8'd0;
            q_idx_q    <= 8'd0;
            data_out_q <= 1'b0;
            bin_val_q  <= '0;
            i_out_q    <= 8'd0;
            q_out_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            i_idx_q    <= i_idx_d;
            q_idx_q    <= q_idx_d;
            data_out_q <= data_out_d;
            bin_val_q  <= bin_val_d;
            i_out_q    <= i_out_d;
            q_out_q    <= q_out_d;
        end
    end

    // Bin storage. Accumulation only happens in IDLE and read-clear only on
    // emitted bins; the one overlap (start cycle, bin 0) lets the clear win,
    // matching the value that was read out.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBINS; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (acc_en) begin
                mem_q[acc_addr] <= inc_val;
            end
            if (CLEAR_ON_READ && emit_en) begin
                mem_q[emit_addr] <= '0;
            end
        end
    end

    assign data_out  = data_out_q;
    assign bin_val   = bin_val_q;
    assign i_bin_out = i_out_q;
    assign q_bin_out = q_out_q;

endmodule

// File: tb/tb_hist2d_bin_out_stream.sv
// tb/tb_hist2d_bin_out_stream.sv - self-checking bench for hist2d_bin_out_stream

module tb_hist2d_bin_out_stream;

    localparam int AXIS_W = 4;
    localparam int CNT_W  = 4;
    localparam int NAX    = 16;
    localparam int CMAX   = 15;

`ifdef HIST2D_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic             clk100 = 1'b0;
    logic             rst_n = 1'b0;
    logic             data_in = 1'b0;
    logic [7:0]       i_bin_coord = 8'd0;
    logic [7:0]       q_bin_coord = 8'd0;
    logic             start_data_out = 1'b0;
    logic [15:0]      num_data_pts = 16'd0;
    logic [7:0]       i_bin_num = 8'd10;
    logic [7:0]       q_bin_num = 8'd10;
    logic             data_out;
    logic [CNT_W-1:0] bin_val;
    logic [7:0]       i_bin_out;
    logic [7:0]       q_bin_out;

    int checks = 0;
    int failures = 0;
    int model [NAX*NAX];
    int acc_model = 0;

    always #5 clk100 = ~clk100;

    hist2d_bin_out_stream #(.AXIS_W(AXIS_W), .CNT_W(CNT_W)) dut (
        .clk100(clk100), .rst_n(rst_n), .data_in(data_in),
        .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
        .start_data_out(start_data_out), .num_data_pts(num_data_pts),
        .i_bin_num(i_bin_num), .q_bin_num(q_bin_num),
        .data_out(data_out), .bin_val(bin_val),
        .i_bin_out(i_bin_out), .q_bin_out(q_bin_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input int n);
        return (n > NAX) ? NAX : n;
    endfunction

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NAX*NAX; k++) model[k] = 0;
        acc_model = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_in = 1'b0;
        start_data_out = 1'b0;
        clear_model();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic sample(input int i, input int q);
        data_in = 1'b1;
        i_bin_coord = 8'(i);
        q_bin_coord = 8'(q);
        if (i < eff(i_bin_num) && q < eff(q_bin_num) && acc_model < int'(num_data_pts)) begin
            if (model[q*NAX+i] < CMAX) model[q*NAX+i]++;
            acc_model++;
        end
        step();
        data_in = 1'b0;
    endtask

    // Streams the histogram and compares every beat with the model.
    // mid_start pulses start_data_out during the stream; rst_beat >= 0 aborts
    // with reset at that beat.
    task automatic run_stream(input bit mid_start, input int rst_beat);
        int ie, qe, n, ii, qq;
        ie = eff(i_bin_num);
        qe = eff(q_bin_num);
        n = ie * qe;
        start_data_out = 1'b1;
        step();
        start_data_out = 1'b0;
        if (n == 0) begin
            for (int k = 0; k < 10; k++) begin
                chk("no_beat_zero_bins", 64'(data_out), 64'd0);
                step();
            end
            return;
        end
        for (int b = 0; b < n; b++) begin
            if (b == rst_beat) begin
                rst_n = 1'b0;
                data_in = 1'b0;
                #1;
                chk("reset_abort_outputs", 64'({data_out, i_bin_out, q_bin_out, bin_val}), 64'd0);
                clear_model();
                step();
                rst_n = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    chk("no_beat_after_reset", 64'(data_out), 64'd0);
                    step();
                end
                return;
            end
            ii = b % ie;
            qq = b / ie;
            chk($sformatf("beat%0d", b),
                64'({data_out, i_bin_out, q_bin_out, bin_val}),
                64'({1'b1, 8'(ii), 8'(qq), CNT_W'(model[qq*NAX+ii])}));
            if (CLR) model[qq*NAX+ii] = 0;
            // Samples and starts during the stream must be ignored.
            start_data_out = mid_start && (b == n / 2);
            data_in = 1'($urandom_range(0, 1));
            i_bin_coord = 8'($urandom_range(0, ie - 1));
            q_bin_coord = 8'($urandom_range(0, qe - 1));
            step();
        end
        data_in = 1'b0;
        start_data_out = 1'b0;
        chk("end_of_stream", 64'(data_out), 64'd0);
        if (CLR) acc_model = 0;
        step();
        chk("no_restart", 64'(data_out), 64'd0);
    endtask

    initial begin
        clear_model();
        #12;
        chk("reset_outputs", 64'({data_out, i_bin_out, q_bin_out, bin_val}), 64'd0);
        rst_n = 1'b1;
        step();

        // Four sparse samples, 10x10 grid.
        i_bin_num = 8'd10; q_bin_num = 8'd10; num_data_pts = 16'd5;
        sample(0, 0); sample(2, 1); sample(4, 2); sample(6, 3);
        step();
        run_stream(1'b0, -1);

        // Sample limit.
        do_reset();
        num_data_pts = 16'd3;
        for (int k = 0; k < 5; k++) sample(1, 1);
        run_stream(1'b0, -1);

        // Out-of-range coordinates; zero sample limit.
        do_reset();
        num_data_pts = 16'd10;
        sample(10, 2); sample(2, 10); sample(255, 0);
        run_stream(1'b0, -1);
        num_data_pts = 16'd0;
        sample(3, 3);
        run_stream(1'b0, -1);

        // Mid-stream start ignored; second stream checks read side effects.
        do_reset();
        num_data_pts = 16'd50;
        for (int k = 0; k < 30; k++) sample($urandom_range(0, 11), $urandom_range(0, 11));
        run_stream(1'b1, -1);
        run_stream(1'b1, -1);

        // Reset mid-stream, then confirm the bins were cleared.
        for (int k = 0; k < 10; k++) sample($urandom_range(0, 9), $urandom_range(0, 9));
        run_stream(1'b0, 40);
        run_stream(1'b0, -1);

        // No active I bins.
        i_bin_num = 8'd0;
        sample(0, 0);
        run_stream(1'b0, -1);

        // Counter saturation.
        do_reset();
        i_bin_num = 8'd4; q_bin_num = 8'd4; num_data_pts = 16'd40;
        for (int k = 0; k < 20; k++) sample(3, 2);
        run_stream(1'b0, -1);

        // Randomized rounds, including axis clamping above the grid size.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            i_bin_num = 8'($urandom_range(1, 20));
            q_bin_num = 8'($urandom_range(1, 20));
            num_data_pts = 16'($urandom_range(0, 60));
            for (int k = 0; k < 40; k++) begin
                sample($urandom_range(0, 21), $urandom_range(0, 21));
                if ($urandom_range(0, 3) == 0) step();
            end
            run_stream(1'b0, -1);
            for (int k = 0; k < 8; k++) sample($urandom_range(0, 21), $urandom_range(0, 21));
            run_stream(1'b1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
